pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register placed between any two stages of the 5-stage RV32 core (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle, packed from the stage structs, with valid/ready flow control, synchronous flush with bubble insertion, and a stall-cycle counter. It is the generic successor to the fixed, per-stage struct registers and replaces hand-written stall/flush logic in each stage.

---
 rtl/pipe_stage_reg.sv | 146 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Purpose : generic RV32 pipeline stage register (ctrl + data bundle) with valid/ready, flush and stall counter.
// Latency : one cycle from in_fire to out_valid; one transfer per cycle while out_ready is high.
// Backpr. : skid build keeps a second entry and a registered in_ready; default build stalls in_ready combinationally.
//
// Build option: define PIPE_STAGE_SKID_EN for the two-entry skid buffer (states EMPTY/ONE/TWO).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_ctrl/in_data payload
//   out_valid/out_ready   downstream handshake; out_ctrl (zero when idle) / out_data (holds last value)
//   flush                 synchronous kill of every held entry and of any beat accepted in the same cycle
//   stall_cnt             saturating count of cycles with out_valid && !out_ready
module pipe_stage_reg #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 105,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_fire;
    logic              out_fire;

`ifdef PIPE_STAGE_SKID_EN
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;

    // Depends only on the state register, so out_ready never reaches in_ready combinationally.
    assign in_ready = (state_q != ST_TWO);
`else
    assign in_ready = !out_valid || out_ready;
`endif

    assign out_valid = (state_q != ST_EMPTY);
    // m_ctrl_q is zeroed whenever the stage goes empty, so no output gating is needed.
    assign out_ctrl  = m_ctrl_q;
    assign out_data  = m_data_q;
    assign stall_cnt = cnt_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
`ifdef PIPE_STAGE_SKID_EN
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d  = ST_ONE;
                    m_ctrl_d = in_ctrl;
                    m_data_d = in_data;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    m_ctrl_d = in_ctrl;
                    m_data_d = in_data;
`ifdef PIPE_STAGE_SKID_EN
                end else if (in_fire) begin
                    // Downstream stalled while a beat was in flight: park it in the skid slot.
                    state_d  = ST_TWO;
                    s_ctrl_d = in_ctrl;
                    s_data_d = in_data;
`endif
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
`ifdef PIPE_STAGE_SKID_EN
            ST_TWO: begin
                if (out_fire) begin
                    state_d  = ST_ONE;
                    m_ctrl_d = s_ctrl_q;
                    m_data_d = s_data_q;
                end
            end
`endif
            default: state_d = ST_EMPTY;
        endcase

        // Flush drops everything, including a beat accepted this cycle; the data
        // register is left untouched so out_data keeps showing the last value.
        if (flush) begin
            state_d  = ST_EMPTY;
            m_data_d = m_data_q;
        end

        if (state_d == ST_EMPTY) begin
            m_ctrl_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            m_ctrl_q <= '0;
            m_data_q <= '0;
            cnt_q    <= '0;
`ifdef PIPE_STAGE_SKID_EN
            s_ctrl_q <= '0;
            s_data_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            m_ctrl_q <= m_ctrl_d;
            m_data_q <= m_data_d;
            cnt_q    <= cnt_d;
`ifdef PIPE_STAGE_SKID_EN
            s_ctrl_q <= s_ctrl_d;
            s_data_q <= s_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a default-width instance and a CNT_W=4 instance share stimulus.
// Expected behaviour comes from a queue-based model of the stage plus a streaming vector table.
`timescale 1ns/1ps
module tb_pipe_stage_reg;
    localparam int CW = 9;
    localparam int DW = 105;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cnt;
    logic          in_ready4, out_valid4;
    logic [CW-1:0] out_ctrl4;
    logic [DW-1:0] out_data4;
    logic [3:0]    stall_cnt4;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .flush(flush), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
        .out_ctrl(out_ctrl4), .out_data(out_data4), .flush(flush), .stall_cnt(stall_cnt4)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic [DW-1:0] m_last = '0;
    int            m_cnt16 = 0;
    int            m_cnt4 = 0;
    int            checks = 0;
    int            failures = 0;

    function automatic logic mdl_rdy(input logic ordy);
`ifdef PIPE_STAGE_SKID_EN
        return (mq.size() < 2);
`else
        return (mq.size() == 0) || ordy;
`endif
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_model();
        logic          ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        logic          er;
        ev = (mq.size() > 0);
        ec = '0;
        ed = m_last;
        if (ev) begin
            ec = mq[0].c;
            ed = mq[0].d;
        end
        er = mdl_rdy(out_ready);
        chk("out_valid", out_valid, ev);
        chk("out_ctrl", out_ctrl, ec);
        chk("out_data", out_data, ed);
        chk("in_ready", in_ready, er);
        chk("stall_cnt", stall_cnt, m_cnt16);
        chk("out_valid4", out_valid4, ev);
        chk("out_ctrl4", out_ctrl4, ec);
        chk("out_data4", out_data4, ed);
        chk("in_ready4", in_ready4, er);
        chk("stall_cnt4", stall_cnt4, m_cnt4);
    endtask

    task automatic model_update();
        logic acc;
        ent_t e;
        acc = in_valid && mdl_rdy(out_ready);
        if (mq.size() > 0) begin
            m_last = mq[0].d;
            if (!out_ready) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
        if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (acc) begin
                e.c = in_ctrl;
                e.d = in_data;
                mq.push_back(e);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Asserts reset between edges and checks outputs before any clock edge arrives.
    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_ctrl", out_ctrl, '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_stall_cnt", stall_cnt, '0);
        chk("rst_stall_cnt4", stall_cnt4, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        m_last  = '0;
        m_cnt16 = 0;
        m_cnt4  = 0;
    endtask

    typedef struct {
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        logic          erdy;
    } vec_t;

    vec_t          tbl[9];
    logic [DW-1:0] outs[$];
    int            nxt;
    logic          ordy_c;
    logic          acc_c;
    logic [127:0]  r;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming table: payloads 1..8, out_ready high, one-cycle latency.
        for (int k = 0; k < 9; k++) begin
            tbl[k].iv   = (k < 8);
            tbl[k].ic   = 9'h100 | CW'(k + 1);
            tbl[k].id   = DW'(k + 1);
            tbl[k].ordy = 1'b1;
            tbl[k].ev   = (k > 0);
            tbl[k].ec   = (k > 0) ? (9'h100 | CW'(k)) : '0;
            tbl[k].ed   = DW'(k);
            tbl[k].erdy = 1'b1;
        end

        do_reset();

        for (int k = 0; k < 9; k++) begin
            drive(tbl[k].iv, tbl[k].ic, tbl[k].id, tbl[k].ordy, 1'b0);
            sample();
            chk("tbl_out_valid", out_valid, tbl[k].ev);
            chk("tbl_out_ctrl", out_ctrl, tbl[k].ec);
            chk("tbl_out_data", out_data, tbl[k].ed);
            chk("tbl_in_ready", in_ready, tbl[k].erdy);
            chk("tbl_stall_cnt", stall_cnt, '0);
            advance();
        end

        // Reset while a stalled entry is being presented.
        drive(1'b1, 9'h0AA, DW'(85), 1'b0, 1'b0);
        sample();
        advance();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        sample();
        advance();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        sample();
        chk("mid_out_valid_before_rst", out_valid, 1'b1);
        advance();
        do_reset();

        // Saturation: 20 stalled cycles; 4-bit counter stops at 15.
        drive(1'b1, 9'h033, DW'(119), 1'b0, 1'b0);
        sample();
        advance();
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            sample();
            advance();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        sample();
        chk("sat_stall_cnt4", stall_cnt4, 4'd15);
        chk("sat_stall_cnt16", stall_cnt, 16'd20);
        advance();
        do_reset();

        // Backpressure: beats 1..6, out_ready low for 3 cycles while beat 2 is presented.
        nxt = 1;
        outs.delete();
        for (int c = 0; c < 14; c++) begin
            ordy_c = !(c >= 2 && c <= 4);
            drive(nxt <= 6, CW'(nxt), DW'(nxt), ordy_c, 1'b0);
            sample();
            if (c == 2) begin
                chk("bp_beat2_presented", out_data, DW'(2));
`ifdef PIPE_STAGE_SKID_EN
                chk("bp_in_ready_drop_cycle", in_ready, 1'b1);
`else
                chk("bp_in_ready_drop_cycle", in_ready, 1'b0);
`endif
            end
            if (c == 3) chk("bp_in_ready_next_cycle", in_ready, 1'b0);
            if (out_valid && ordy_c) outs.push_back(out_data);
            acc_c = (nxt <= 6) && mdl_rdy(ordy_c);
            advance();
            if (acc_c) nxt++;
        end
        chk("bp_out_count", outs.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < outs.size()) chk("bp_order", outs[i], DW'(i + 1));
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        sample();
        chk("bp_stall_cnt", stall_cnt, 16'd3);
        advance();
        do_reset();

        // Flush with full entries (ctrl all ones) and a beat offered in the flush cycle.
        drive(1'b1, 9'h1FF, DW'(161), 1'b0, 1'b0);
        sample();
        advance();
        drive(1'b1, 9'h1FF, DW'(178), 1'b0, 1'b0);
        sample();
        advance();
        drive(1'b1, 9'h1FF, DW'(195), 1'b0, 1'b1);
        sample();
        chk("fl_ctrl_before", out_ctrl, 9'h1FF);
        chk("fl_in_ready_full", in_ready, 1'b0);
        advance();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        sample();
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_out_ctrl", out_ctrl, '0);
        chk("fl_in_ready", in_ready, 1'b1);
        chk("fl_out_data_held", out_data, DW'(161));
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            sample();
            chk("fl_beat_absent", out_valid, 1'b0);
            advance();
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            drive($urandom_range(0, 9) < 7, CW'($urandom), r[DW-1:0],
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
